// File: rtl/alu_pkg.sv
// Shared ALU op codes, RV32I opcode constants and the decoded-entry record
// used by the ALU issue stage.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SRA = 4'b0111;
    localparam logic [3:0] ALU_BEQ = 4'b1000;
    localparam logic [3:0] ALU_BGE = 4'b1001;
    localparam logic [3:0] ALU_LT  = 4'b1100;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic {SrcbRs2, SrcbImm} srcb_sel_e;

    typedef struct packed {
        logic [3:0]  op;
        srcb_sel_e   srcb_sel;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        reg_write;
        logic        is_branch;
        logic        illegal;
    } alu_entry_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I decoder: instruction word -> ALU op, SrcB selection,
// immediate, destination and control flags.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr_i,
    output alu_entry_t  entry_o
);

    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] i_imm;
    logic [31:0] s_imm;
    logic [31:0] shamt;
    logic        bad;
    alu_entry_t  e;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign i_imm  = {{20{instr_i[31]}}, instr_i[31:20]};
    assign s_imm  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign shamt  = {27'b0, instr_i[24:20]};

    always_comb begin
        e          = '0;
        e.srcb_sel = SrcbRs2;
        bad        = 1'b0;
        case (opcode)
            OPC_OP: begin
                e.reg_write = 1'b1;
                case (funct3)
                    3'b000: begin
                        if (funct7 == F7_ZERO)     e.op = ALU_ADD;
                        else if (funct7 == F7_ALT) e.op = ALU_SUB;
                        else                       bad  = 1'b1;
                    end
                    3'b101: begin
                        if (funct7 == F7_ZERO)     e.op = ALU_SRL;
                        else if (funct7 == F7_ALT) e.op = ALU_SRA;
                        else                       bad  = 1'b1;
                    end
                    3'b111:  begin e.op = ALU_AND; bad = (funct7 != F7_ZERO); end
                    3'b110:  begin e.op = ALU_OR;  bad = (funct7 != F7_ZERO); end
                    3'b100:  begin e.op = ALU_XOR; bad = (funct7 != F7_ZERO); end
                    3'b001:  begin e.op = ALU_SLL; bad = (funct7 != F7_ZERO); end
                    3'b010:  begin e.op = ALU_LT;  bad = (funct7 != F7_ZERO); end
                    default: bad = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                e.reg_write = 1'b1;
                e.srcb_sel  = SrcbImm;
                e.imm       = i_imm;
                case (funct3)
                    3'b000: e.op = ALU_ADD;
                    3'b111: e.op = ALU_AND;
                    3'b110: e.op = ALU_OR;
                    3'b100: e.op = ALU_XOR;
                    3'b010: e.op = ALU_LT;
                    3'b001: begin
                        e.op  = ALU_SLL;
                        e.imm = shamt;
                        bad   = (funct7 != F7_ZERO);
                    end
                    3'b101: begin
                        e.imm = shamt;
                        if (funct7 == F7_ZERO)     e.op = ALU_SRL;
                        else if (funct7 == F7_ALT) e.op = ALU_SRA;
                        else                       bad  = 1'b1;
                    end
                    default: bad = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                e.op        = ALU_ADD;
                e.srcb_sel  = SrcbImm;
                e.imm       = i_imm;
                e.reg_write = 1'b1;
            end
            OPC_STORE: begin
                e.op       = ALU_ADD;
                e.srcb_sel = SrcbImm;
                e.imm      = s_imm;
            end
            OPC_BRANCH: begin
                e.is_branch = 1'b1;
                case (funct3)
                    3'b000:  e.op = ALU_BEQ;
                    3'b101:  e.op = ALU_BGE;
                    3'b100:  e.op = ALU_LT;
                    default: bad  = 1'b1;
                endcase
            end
            default: bad = 1'b1;
        endcase

        if (bad) begin
            e          = '0;
            e.srcb_sel = SrcbRs2;
            e.illegal  = 1'b1;
        end
        if (e.reg_write) e.rd = instr_i[11:7];
        // Writes to x0 are architecturally discarded.
        if (e.rd == 5'd0) e.reg_write = 1'b0;
    end

    assign entry_o = e;

    logic unused_rs1;
    assign unused_rs1 = ^instr_i[19:15];

endmodule

// File: rtl/alu_op_issue_stage.sv
// One-entry valid/ready issue register feeding the ALU with op code and operands.
// Optional first-illegal-instruction capture under ALU_ISSUE_ILLEGAL_CAPTURE_EN.
module alu_op_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned OPCODE_LENGTH = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [31:0]              instr_i,
    input  logic [DATA_WIDTH-1:0]    rs1_data_i,
    input  logic [DATA_WIDTH-1:0]    rs2_data_i,
    input  logic                     flush_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [OPCODE_LENGTH-1:0] operation_o,
    output logic [DATA_WIDTH-1:0]    src_a_o,
    output logic [DATA_WIDTH-1:0]    src_b_o,
    output logic [4:0]               rd_o,
    output logic                     reg_write_o,
    output logic                     is_branch_o,
`ifdef ALU_ISSUE_ILLEGAL_CAPTURE_EN
    output logic                     illegal_seen_o,
    output logic [31:0]              illegal_instr_o,
`endif
    output logic                     illegal_o
);

    alu_entry_t entry;
    logic       load;

    logic                     valid_d, valid_q;
    logic [OPCODE_LENGTH-1:0] op_d, op_q;
    logic [DATA_WIDTH-1:0]    src_a_d, src_a_q, src_b_d, src_b_q;
    logic [4:0]               rd_d, rd_q;
    logic                     reg_write_d, reg_write_q;
    logic                     is_branch_d, is_branch_q;
    logic                     illegal_d, illegal_q;

    alu_op_decode u_decode (
        .instr_i (instr_i),
        .entry_o (entry)
    );

    assign in_ready_o = !valid_q || out_ready_i;
    // A flush drops a same-cycle input, so it never counts as accepted.
    assign load       = in_valid_i && in_ready_o && !flush_i;

    always_comb begin
        valid_d     = valid_q;
        op_d        = op_q;
        src_a_d     = src_a_q;
        src_b_d     = src_b_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        is_branch_d = is_branch_q;
        illegal_d   = illegal_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d     = 1'b1;
            op_d        = OPCODE_LENGTH'(entry.op);
            src_a_d     = rs1_data_i;
            src_b_d     = (entry.srcb_sel == SrcbImm) ? DATA_WIDTH'($signed(entry.imm))
                                                      : rs2_data_i;
            rd_d        = entry.rd;
            reg_write_d = entry.reg_write;
            is_branch_d = entry.is_branch;
            illegal_d   = entry.illegal;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            valid_q     <= 1'b0;
            op_q        <= '0;
            src_a_q     <= '0;
            src_b_q     <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            is_branch_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            op_q        <= op_d;
            src_a_q     <= src_a_d;
            src_b_q     <= src_b_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            is_branch_q <= is_branch_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out_valid_o = valid_q;
    assign operation_o = op_q;
    assign src_a_o     = src_a_q;
    assign src_b_o     = src_b_q;
    assign rd_o        = rd_q;
    assign reg_write_o = reg_write_q;
    assign is_branch_o = is_branch_q;
    assign illegal_o   = illegal_q;

`ifdef ALU_ISSUE_ILLEGAL_CAPTURE_EN
    logic        illegal_seen_d, illegal_seen_q;
    logic [31:0] illegal_instr_d, illegal_instr_q;

    always_comb begin
        illegal_seen_d  = illegal_seen_q;
        illegal_instr_d = illegal_instr_q;
        if (load && entry.illegal && !illegal_seen_q) begin
            illegal_seen_d  = 1'b1;
            illegal_instr_d = instr_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            illegal_seen_q  <= 1'b0;
            illegal_instr_q <= '0;
        end else begin
            illegal_seen_q  <= illegal_seen_d;
            illegal_instr_q <= illegal_instr_d;
        end
    end

    assign illegal_seen_o  = illegal_seen_q;
    assign illegal_instr_o = illegal_instr_q;
`endif

endmodule
